// File: rtl/voice_allocator.sv
// voice_allocator: polyphony controller assigning note events to notebank voices, stealing the oldest held voice
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W = 7,
    parameter int AGE_W = 2
) (
    input  logic                         clk_slow,
    input  logic                         rst_b,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [NUM_VOICES-1:0]        voice_done,
    output logic [NUM_VOICES-1:0]        voice_note_on,
    output logic [NUM_VOICES-1:0]        voice_note_off,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         steal
);
    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} fsm_t;
    typedef enum logic [1:0] {FREE, HELD, RELEASING} vst_t;
    localparam logic [AGE_W-1:0] LAST = AGE_W'(NUM_VOICES - 1);
    fsm_t fsm;
    vst_t vst [NUM_VOICES];
    logic [AGE_W-1:0] age [NUM_VOICES];
    logic [NOTE_W-1:0] vnote [NUM_VOICES];
    logic [NOTE_W-1:0] note_q;
    logic on_q;
    logic [AGE_W-1:0] idx;
    logic m_ok, f_ok, r_ok, h_ok;
    logic [AGE_W-1:0] m_idx, f_idx, r_idx, h_idx;
    logic nm_ok, nf_ok, nr_ok, nh_ok;
    logic [AGE_W-1:0] nm_idx, nf_idx, nr_idx, nh_idx;
    logic [AGE_W-1:0] sel;
    logic act, stl;
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign voice_note[v*NOTE_W +: NOTE_W] = vnote[v];
        assign voice_active[v] = vst[v] != FREE;
    end
    always_comb begin
        nm_ok = m_ok;
        nm_idx = m_idx;
        nf_ok = f_ok;
        nf_idx = f_idx;
        nr_ok = r_ok;
        nr_idx = r_idx;
        nh_ok = h_ok;
        nh_idx = h_idx;
        if (!m_ok && vst[idx] == HELD && vnote[idx] == note_q) begin
            nm_ok = 1'b1;
            nm_idx = idx;
        end
        if (!f_ok && vst[idx] == FREE) begin
            nf_ok = 1'b1;
            nf_idx = idx;
        end
        if (!r_ok && vst[idx] == RELEASING) begin
            nr_ok = 1'b1;
            nr_idx = idx;
        end
        if (vst[idx] == HELD && (!h_ok || age[idx] > age[h_idx])) begin
            nh_ok = 1'b1;
            nh_idx = idx;
        end
        stl = on_q && !nm_ok && !nf_ok && !nr_ok;
        act = on_q || nm_ok;
        sel = (nm_ok || !on_q) ? nm_idx : nf_ok ? nf_idx : nr_ok ? nr_idx : nh_idx;
    end
    always_ff @(posedge clk_slow) begin
        if (!rst_b) begin
            fsm <= IDLE;
            ev_ready <= 1'b0;
            voice_note_on <= '0;
            voice_note_off <= '0;
            steal <= 1'b0;
            idx <= '0;
            on_q <= 1'b0;
            note_q <= '0;
            {m_ok, f_ok, r_ok, h_ok} <= '0;
            {m_idx, f_idx, r_idx, h_idx} <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vst[i] <= FREE;
                vnote[i] <= '0;
                age[i] <= AGE_W'(i);
            end
        end else begin
            voice_note_on <= '0;
            voice_note_off <= '0;
            steal <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++)
                if (voice_done[i] && vst[i] == RELEASING) vst[i] <= FREE;
            if (fsm == IDLE) begin
                ev_ready <= !(ev_valid && ev_ready);
                if (ev_valid && ev_ready) begin
                    on_q <= ev_on;
                    note_q <= ev_note;
                    idx <= '0;
                    {m_ok, f_ok, r_ok, h_ok} <= '0;
                    fsm <= SCAN;
                end
            end else if (fsm == SCAN) begin
                {m_ok, f_ok, r_ok, h_ok} <= {nm_ok, nf_ok, nr_ok, nh_ok};
                {m_idx, f_idx, r_idx, h_idx} <= {nm_idx, nf_idx, nr_idx, nh_idx};
                idx <= idx + 1'b1;
                if (idx == LAST) begin
                    fsm <= ISSUE;
                    if (act && on_q) begin
                        voice_note_on[sel] <= 1'b1;
                        vnote[sel] <= note_q;
                        vst[sel] <= HELD;
                        steal <= stl;
                        for (int i = 0; i < NUM_VOICES; i++)
                            age[i] <= (AGE_W'(i) == sel) ? '0 : (age[i] < age[sel]) ? age[i] + 1'b1 : age[i];
                    end else if (act) begin
                        voice_note_off[sel] <= 1'b1;
                        vst[sel] <= RELEASING;
                    end
                end
            end else begin
                fsm <= IDLE;
                ev_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench checking the allocator against a recency-list voice model
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int NW = 7;
    logic clk_slow, rst_b, ev_valid, ev_ready, ev_on, steal;
    logic [NW-1:0] ev_note;
    logic [NV-1:0] voice_done, voice_note_on, voice_note_off, voice_active;
    logic [NV*NW-1:0] voice_note;
    typedef struct {
        int cyc;
        logic [NV-1:0] on_m;
        logic [NV-1:0] off_m;
        logic stl;
        logic [NV*NW-1:0] notes;
        logic [NV-1:0] act;
    } exp_t;
    exp_t sbq[$];
    exp_t got;
    int st[NV];
    int nt[NV];
    int rq[$];
    int ncyc = 0;
    int stray = 0;
    int errors = 0;
    int checks = 0;
    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .AGE_W(2)) dut (
        .clk_slow(clk_slow), .rst_b(rst_b), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .voice_done(voice_done),
        .voice_note_on(voice_note_on), .voice_note_off(voice_note_off),
        .voice_note(voice_note), .voice_active(voice_active), .steal(steal)
    );
    initial begin
        clk_slow = 0;
        forever #5 clk_slow = ~clk_slow;
    end
    task automatic chk(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, ncyc);
        end
    endtask
    function automatic logic [NV-1:0] model_act();
        logic [NV-1:0] a = '0;
        for (int v = 0; v < NV; v++) a[v] = st[v] != 0;
        return a;
    endfunction
    function automatic logic [NV*NW-1:0] model_notes();
        logic [NV*NW-1:0] n = '0;
        for (int v = 0; v < NV; v++) n[v*NW +: NW] = nt[v][NW-1:0];
        return n;
    endfunction
    function automatic void model_reset();
        rq.delete();
        for (int v = 0; v < NV; v++) begin
            st[v] = 0;
            nt[v] = 0;
            rq.push_back(v);
        end
    endfunction
    task automatic model_event(input bit on, input int note, output bit pulse, output exp_t e);
        int m = -1;
        int sel = -1;
        int pos = 0;
        for (int v = 0; v < NV; v++) if (m < 0 && st[v] == 1 && nt[v] == note) m = v;
        e.on_m = '0;
        e.off_m = '0;
        e.stl = 0;
        if (on) begin
            sel = m;
            for (int v = 0; v < NV; v++) if (sel < 0 && st[v] == 0) sel = v;
            for (int v = 0; v < NV; v++) if (sel < 0 && st[v] == 2) sel = v;
            if (sel < 0) begin
                e.stl = 1;
                for (int k = rq.size() - 1; k >= 0; k--) if (sel < 0 && st[rq[k]] == 1) sel = rq[k];
            end
            st[sel] = 1;
            nt[sel] = note;
            for (int k = 0; k < rq.size(); k++) if (rq[k] == sel) pos = k;
            rq.delete(pos);
            rq.push_front(sel);
            e.on_m[sel] = 1'b1;
        end else if (m >= 0) begin
            st[m] = 2;
            e.off_m[m] = 1'b1;
        end
        pulse = on || m >= 0;
        e.notes = model_notes();
        e.act = model_act();
    endtask
    always @(negedge clk_slow) begin
        ncyc++;
        if (|voice_note_on || |voice_note_off || steal) begin
            if (sbq.size() == 0) begin
                stray++;
                chk("stray_pulse", {voice_note_on, voice_note_off, steal}, 0);
            end else begin
                got = sbq.pop_front();
                chk("pulse_cycle", ncyc, got.cyc);
                chk("note_on", voice_note_on, got.on_m);
                chk("note_off", voice_note_off, got.off_m);
                chk("steal", steal, got.stl);
                chk("voice_note", voice_note, got.notes);
                chk("active_at_pulse", voice_active, got.act);
            end
        end
    end
    task automatic chk_zero();
        chk("rst_ready", ev_ready, 0);
        chk("rst_pulses", {voice_note_on, voice_note_off, steal}, 0);
        chk("rst_notes", voice_note, 0);
        chk("rst_active", voice_active, 0);
    endtask
    task automatic do_reset();
        @(negedge clk_slow); #1;
        rst_b = 0;
        @(negedge clk_slow); #1;
        chk_zero();
        rst_b = 1;
        model_reset();
        @(negedge clk_slow); #1;
        chk("post_rst_ready", ev_ready, 1);
        chk("post_rst_active", voice_active, 0);
    endtask
    task automatic send(input bit on, input int note);
        int n = 0;
        bit pulse;
        exp_t e;
        @(negedge clk_slow); #1;
        while (!ev_ready && n < 20) begin
            @(negedge clk_slow); #1;
            n++;
        end
        if (!ev_ready) begin
            chk("ready_timeout", ev_ready, 1);
            return;
        end
        model_event(on, note, pulse, e);
        e.cyc = ncyc + NV + 1;
        if (pulse) sbq.push_back(e);
        ev_valid = 1;
        ev_on = on;
        ev_note = NW'(note);
        @(posedge clk_slow); #1;
        ev_valid = 0;
        n = 0;
        do begin
            @(negedge clk_slow); #1;
            n++;
        end while (!ev_ready && n < 20);
        chk("ready_latency", n, NV + 2);
        chk("active_after_event", voice_active, model_act());
    endtask
    task automatic done_pulse(input logic [NV-1:0] m);
        @(negedge clk_slow); #1;
        voice_done = m;
        @(negedge clk_slow); #1;
        voice_done = '0;
        for (int v = 0; v < NV; v++) if (m[v] && st[v] == 2) st[v] = 0;
        chk("active_after_done", voice_active, model_act());
    endtask
    initial begin
        rst_b = 0;
        ev_valid = 0;
        ev_on = 0;
        ev_note = '0;
        voice_done = '0;
        model_reset();
        do_reset();
        send(1, 60);
        foreach (st[i]) ;
        send(1, 62); send(1, 64); send(1, 65); send(1, 62);
        send(1, 67); send(1, 69);
        do_reset();
        send(1, 60); send(1, 62); send(1, 64); send(1, 65);
        send(0, 64); send(1, 70);
        send(0, 65);
        done_pulse(4'b1000);
        send(1, 72);
        do_reset();
        send(0, 50);
        chk("unmatched_no_pulse", stray, 0);
        @(negedge clk_slow); #1;
        ev_valid = 1;
        ev_on = 1;
        ev_note = 60;
        @(posedge clk_slow); #1;
        ev_valid = 0;
        @(posedge clk_slow); #1;
        rst_b = 0;
        @(negedge clk_slow); #1;
        @(negedge clk_slow); #1;
        chk_zero();
        rst_b = 1;
        model_reset();
        repeat (12) @(negedge clk_slow);
        #1;
        chk("scan_rst_no_pulse", stray, 0);
        chk("scan_rst_ready", ev_ready, 1);
        chk("scan_rst_active", voice_active, 0);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 3) done_pulse(NV'($urandom_range(0, 15)));
            send($urandom_range(0, 9) < 6, 60 + $urandom_range(0, 5));
        end
        repeat (10) @(negedge clk_slow);
        chk("sb_drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
